// File: rtl/det_collect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : det_pkg                                                   |
// | Purpose  : Shared constants for the detection collector: frame size,  |
// |            default widths and the collector state encoding.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package det_pkg;

  // Pixels per frame; the position index must cover 0..FRAME_SIZE-1.
  localparam int FRAME_SIZE = 4800;

  localparam int DEF_SUM_W = 16;
  localparam int DEF_POS_W = $clog2(FRAME_SIZE);

  // Collector state encoding (2-bit, legacy-compatible values).
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

endpackage : det_pkg
`default_nettype wire

// File: rtl/det_collect_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : det_collect_if                                           |
// | Purpose   : Score input, frame control and hit-list output bundle of |
// |             the detection collector.                                 |
// |             DET_COLLECT_MAX_EN adds the running-maximum outputs.     |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface det_collect_if
  import det_pkg::*;
#(
  parameter int SUM_W = DEF_SUM_W,
  parameter int POS_W = DEF_POS_W,
  parameter int CNT_W = 8
) ();

  logic             iStart;
  logic             iSum_valid;
  logic [SUM_W-1:0] iSum;
  logic [POS_W-1:0] iPosition;
  logic [SUM_W-1:0] iThreshold;
  logic             iFrame_done;
  logic             oHit_valid;
  logic [POS_W-1:0] oHit_pos;
  logic             iHit_ready;
  logic [CNT_W-1:0] oHit_count;
  logic             oOverflow;
  logic             oBusy;
  logic             oDone;
`ifdef DET_COLLECT_MAX_EN
  logic [SUM_W-1:0] oMax_sum;
  logic [POS_W-1:0] oMax_pos;
`endif

  // Producer side: drives scores/control, consumes hits.
  modport master (
    output iStart, iSum_valid, iSum, iPosition, iThreshold, iFrame_done, iHit_ready,
`ifdef DET_COLLECT_MAX_EN
    input  oMax_sum, oMax_pos,
`endif
    input  oHit_valid, oHit_pos, oHit_count, oOverflow, oBusy, oDone
  );

  // Collector side.
  modport slave (
    input  iStart, iSum_valid, iSum, iPosition, iThreshold, iFrame_done, iHit_ready,
`ifdef DET_COLLECT_MAX_EN
    output oMax_sum, oMax_pos,
`endif
    output oHit_valid, oHit_pos, oHit_count, oOverflow, oBusy, oDone
  );

endinterface : det_collect_if
`default_nettype wire

// File: rtl/det_collect_hit_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : det_hit_fifo                                              |
// | Purpose  : Synchronous first-word-fall-through FIFO with registered  |
// |            storage, synchronous clear and async active-low reset.    |
// |            Pointers carry one extra wrap bit for full/empty.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module det_hit_fifo
  import det_pkg::*;
#(
  parameter int WIDTH = DEF_POS_W,
  parameter int DEPTH = 16
) (
  input  wire logic             iClk,
  input  wire logic             iReset_n,
  input  wire logic             iClr,
  input  wire logic             iPush,
  input  wire logic [WIDTH-1:0] iData,
  input  wire logic             iPop,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic [WIDTH-1:0]      oHead
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign oEmpty    = (r_wr_ptr == r_rd_ptr);
  assign oFull     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = iPush & ~oFull;
  assign w_do_pop  = iPop & ~oEmpty;
  assign oHead     = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB wraps naturally modulo 2*DEPTH.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (iClr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; reset to zero so the head reads 0 after reset.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= iData;
    end
  end

endmodule : det_hit_fifo
`default_nettype wire

// File: rtl/det_collect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : det_collect                                               |
// | Purpose  : Compares window scores to a threshold, buffers hit        |
// |            positions, and drains them by valid/ready after frame end.|
// |            Counts hits (saturating) and flags dropped hits.          |
// |            Optional macro DET_COLLECT_MAX_EN adds a max-score tracker.|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module det_collect
  import det_pkg::*;
#(
  parameter int SUM_W = DEF_SUM_W,
  parameter int POS_W = DEF_POS_W,
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  wire logic     iClk,
  input  wire logic     iReset_n,
  det_collect_if.slave  bus
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             w_in_idle;
  logic             w_in_collect;
  logic             w_in_drain;
  logic             w_start;
  logic             w_hit;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [POS_W-1:0] w_head;
  logic [CNT_W-1:0] r_hit_count;
  logic             r_overflow;

  assign w_in_idle    = (r_state == ST_IDLE);
  assign w_in_collect = (r_state == ST_COLLECT);
  assign w_in_drain   = (r_state == ST_DRAIN);

  // Start is only honoured from IDLE; mid-frame pulses are ignored.
  assign w_start = w_in_idle & bus.iStart;
  assign w_hit   = w_in_collect & bus.iSum_valid & (bus.iSum >= bus.iThreshold);
  assign w_push  = w_hit & ~w_full;
  assign w_pop   = w_in_drain & ~w_empty & bus.iHit_ready;

  det_hit_fifo #(
    .WIDTH (POS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .iClr     (w_start),
    .iPush    (w_push),
    .iData    (bus.iPosition),
    .iPop     (w_pop),
    .oFull    (w_full),
    .oEmpty   (w_empty),
    .oHead    (w_head)
  );

  // Next-state selection for the IDLE -> COLLECT -> DRAIN cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (bus.iStart)      w_state_nxt = ST_COLLECT;
      ST_COLLECT: if (bus.iFrame_done) w_state_nxt = ST_DRAIN;
      ST_DRAIN:   if (w_empty)         w_state_nxt = ST_IDLE;
      default:                         w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Saturating per-frame hit counter; every hit counts, pushed or dropped.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)                          r_hit_count <= '0;
    else if (w_start)                       r_hit_count <= '0;
    else if (w_hit && (r_hit_count != '1))  r_hit_count <= r_hit_count + 1'b1;
  end

  // Sticky overflow: a hit arrived while the FIFO was full.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)            r_overflow <= 1'b0;
    else if (w_start)         r_overflow <= 1'b0;
    else if (w_hit && w_full) r_overflow <= 1'b1;
  end

  assign bus.oHit_valid = w_in_drain & ~w_empty;
  assign bus.oHit_pos   = bus.oHit_valid ? w_head : '0;
  assign bus.oDone      = w_in_drain & w_empty;
  assign bus.oBusy      = ~w_in_idle;
  assign bus.oHit_count = r_hit_count;
  assign bus.oOverflow  = r_overflow;

`ifdef DET_COLLECT_MAX_EN
  logic [SUM_W-1:0] r_max_sum;
  logic [POS_W-1:0] r_max_pos;

  // Running maximum over all valid scores; strict compare keeps the first tie.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_max_sum <= '0;
      r_max_pos <= '0;
    end else if (w_start) begin
      r_max_sum <= '0;
      r_max_pos <= '0;
    end else if (w_in_collect && bus.iSum_valid && (bus.iSum > r_max_sum)) begin
      r_max_sum <= bus.iSum;
      r_max_pos <= bus.iPosition;
    end
  end

  assign bus.oMax_sum = r_max_sum;
  assign bus.oMax_pos = r_max_pos;
`endif

endmodule : det_collect
`default_nettype wire
